// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package arb_pkg;
  localparam int MAX_COUNT = 16;
  localparam int IDX_W     = 4;
  localparam int CNT_W     = 5;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  function automatic logic [MAX_COUNT-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(MAX_COUNT-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping at count-1.
module rr_select import arb_pkg::*; #(
  parameter int unsigned count = 2
) (
  input  logic [count-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  logic [MAX_COUNT-1:0] req_ext;
  logic [IDX_W:0]       c;

  assign req_ext = MAX_COUNT'(req);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    c     = '0;
    for (int i = 0; i < int'(count); i++) begin
      c = {1'b0, ptr} + (IDX_W+1)'(i);
      if (c >= (IDX_W+1)'(count)) c = c - (IDX_W+1)'(count);
      if (!found && req_ext[c[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = c[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with tenure hold, optional timeout preemption and
// a one-cycle grant gap on every owner change. hold_max must not exceed 32.
module bus_arbiter import arb_pkg::*; #(
  parameter int unsigned count    = 2,
  parameter int unsigned hold_max = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [count-1:0] req,
  input  logic [count-1:0] lock,
  output logic [count-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             preempt
);
  localparam logic [CNT_W-1:0] HOLD_LAST = (hold_max == 0) ? '0 : CNT_W'(hold_max - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = (hold_max == 0) ? '1 : HOLD_LAST;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(count - 1);

  arb_state_t           state;
  logic [IDX_W-1:0]     ptr, g, sel_idx, next_ptr;
  logic [CNT_W-1:0]     hold_cnt;
  logic                 sel_found, timeout;
  logic [MAX_COUNT-1:0] req_ext, lock_ext, others;

  assign req_ext  = MAX_COUNT'(req);
  assign lock_ext = MAX_COUNT'(lock);
  assign others   = req_ext & ~onehot(g);
  assign next_ptr = (g == LAST_IDX) ? '0 : g + IDX_W'(1);
  // Timeout only preempts an unlocked owner when someone else is waiting.
  assign timeout  = (hold_max != 0) && (hold_cnt == HOLD_LAST) && !lock_ext[g] && (|others);

  rr_select #(.count(count)) u_sel (
    .req   (req),
    .ptr   (ptr),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= IDLE;
      ptr         <= '0;
      g           <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            state       <= GRANT;
            g           <= sel_idx;
            grant       <= count'(onehot(sel_idx));
            grant_idx   <= sel_idx;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        GRANT: begin
          if (!req_ext[g] || timeout) begin
            state       <= IDLE;
            ptr         <= next_ptr;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            // A release coinciding with timeout is a normal release.
            preempt     <= req_ext[g];
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin bus arbiter that produces the one-hot `select` consumed by the `bmux` read-data/address multiplexers in the bus interconnect. It takes up to 16 master request lines and grants the bus to one master at a time. Each grant is held for the master's full tenure, with optional preemption after a maximum hold time. The registered one-hot grant drives `bmux.select` directly, and `grant_idx` is provided for logging and debug.

## Interface
- `count`, 2: number of requesters; legal range 1..16; equals `count` of the downstream `bmux`.
- `hold_max`, 16: maximum tenure in cycles before preemption when another master waits; 0 disables preemption.
- `HCLK` input 1: the block's single clock.
- `HRESETn` input 1: asynchronous, active-low reset.
- `req` input `count`: per-master bus request; a master holds it high for its whole tenure.
- `lock` input `count`: per-master lock; while high for the granted master, preemption is suppressed.
- `grant` output `count`: registered one-hot grant; all-zero when no master owns the bus.
- `grant_idx` output 4: binary index of the granted master; 0 when `grant` is zero.
- `grant_valid` output 1: equals `|grant`.
- `preempt` output 1: one-cycle pulse in the cycle after a tenure ends by timeout.

## Operation
- State machine has two states, IDLE and GRANT. There is also a round-robin pointer `ptr` (4 bits), a tenure counter `hold_cnt` (5 bits, saturating), and the owner index `g`.
- **IDLE:**
  - `grant` = 0.
  - If any `req` bit is high, pick the first set bit at or after `ptr`, scanning upward and wrapping from `count-1` to 0.
  - On the next edge, register `grant` = one-hot(`g`), clear `hold_cnt`, and enter GRANT.
  - If no `req` bit is high, stay in IDLE.
- **GRANT:**
  - `grant` is stable and `hold_cnt` increments each cycle, saturating at `hold_max-1`.
  - Normal release: when `req[g]` = 0, go to IDLE and set `ptr` = (`g`+1) mod `count`.
  - Preemption: when `hold_max` != 0, `hold_cnt` == `hold_max-1`, `lock[g]` = 0, and some other `req` bit is high, go to IDLE, set `ptr` = (`g`+1) mod `count`, and pulse `preempt`.
  - If no other master is waiting, the owner keeps the bus and the counter stays saturated.
- Every change of owner passes through exactly one IDLE cycle with `grant` = 0. During that cycle the `bmux` drives its no-drive value, which serves as bus turnaround.
- Simultaneous events:
  - `req[g]` falling in the same cycle as a timeout is a normal release; `preempt` stays 0.
  - A `req` bit falling in the same cycle IDLE samples it is still granted. The master is released one cycle later (GRANT, then IDLE).
  - `lock` bits of non-owners are ignored.
- `count` = 1: the single master is regranted after every IDLE cycle, and `ptr` stays 0.
- Reset, asserted at any time including mid-tenure:
  - `grant` = 0, `grant_idx` = 0, `grant_valid` = 0, `preempt` = 0.
  - `ptr` = 0, `hold_cnt` = 0, state = IDLE.
  - Arbitration resumes on the first edge after `HRESETn` rises.

## Timing
- Arbitration latency: `req` sampled high at edge k (bus idle), so `grant` is high after edge k. Worst case with all masters requesting is one tenure plus one IDLE cycle per master ahead of it.
- Release latency: `req[g]` sampled low at edge k, so `grant` = 0 after edge k. The next owner is granted after edge k+1.
- Preemption: the owner holds `grant` for exactly `hold_max` cycles, then `grant` = 0 and `preempt` = 1 for one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `arb_pkg` holds:
  - `MAX_COUNT` = 16 and `IDX_W` = 4.
  - The state enum `arb_state_t` {IDLE, GRANT}.
  - The function `onehot(idx)`.
- Sub-module `rr_select` is combinational. It takes `req` and `ptr` and returns the index and a found flag. `bus_arbiter` contains the state, counter and pointer registers.

## Test plan
- Reset, then `req`=2'b01 → `grant`=01 after the first edge. Drop `req` → `grant`=00 for 1 cycle.
- Reset with `req`=4'b1111 held constantly, `hold_max`=4 → grants cycle 0001,0010,0100,1000,0001. Each tenure is 4 cycles, each is followed by 1 zero cycle, and `preempt` pulses each time.
- `hold_max`=4, master 1 holds `lock[1]`=1 with `req[0]` pending → master 1 keeps the bus for 20 cycles and `preempt` stays 0. After `req[1]` drops, master 0 is granted after the IDLE cycle.
- With master 2 owning the bus (`count`=4), drop `req[2]` in the same cycle as the timeout → `preempt`=0, and the next grant goes to master 3 ahead of master 0.
- Assert `HRESETn`=0 asynchronously mid-tenure (`grant`=0100) → `grant`, `grant_idx` and `preempt` are 0 immediately. After release, with `req`=0110, master 1 is granted first (`ptr`=0).
- Connect `grant` to `bmux` (`count`=4, inputs 32'hA0..A3) → `sig_out` follows the granted input and is 0 in the IDLE cycles.
